// File: rtl/fifo_reader_if.sv
// FIFO read-side bus between the reader and a synchronous-read FIFO.
//   ren    : read strobe from the reader, one-cycle pulse per pop
//   empty  : FIFO empty flag, synchronous to clock
//   rdData : read data, valid on the cycle after ren is sampled high
interface fifo_reader_if #(
  parameter int unsigned DATA_W = 15
);
  logic              ren;
  logic              empty;
  logic [DATA_W-1:0] rdData;

  // Reader side
  modport master (
    output ren,
    input  empty,
    input  rdData
  );

  // FIFO side
  modport slave (
    input  ren,
    output empty,
    output rdData
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: pops one entry from a FIFO on a debounced-edge button press
// or on a periodic auto tick, and holds the last popped value.
//   clock, reset : system clock, asynchronous active-high reset
//   button       : raw active-low pushbutton (asynchronous), press = falling edge
//   autoEn       : 1 = pop one entry every TICK_DIV cycles
//   fifo         : FIFO read bus (ren out, empty/rdData in)
//   dataHeld     : last popped value
//   heldValid    : at least one pop completed since reset
//   popCount     : completed pops, modulo 256
//   underrun     : one-cycle pulse when a request is rejected on empty
//   busy         : a pop is in flight
module fifo_reader #(
  parameter int unsigned DATA_W   = 15,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              button,
  input  logic              autoEn,
  fifo_reader_if.master     fifo,
  output logic [DATA_W-1:0] dataHeld,
  output logic              heldValid,
  output logic [7:0]        popCount,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             btn_s1, btn_s2, btn_s3;
  logic             btn_req, auto_req, req;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_last;
  logic             ren_q, ren_d;
  logic             busy_d, underrun_d, capture;

  // Two-flop synchronizer plus edge register; preset to "released"
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_s3 <= 1'b1;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  // Press detected when the synchronized level goes 1 -> 0
  assign btn_req = btn_s3 & ~btn_s2;

  // Auto-drain period counter, held at zero while autoEn is low
  assign tick_last = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!autoEn || tick_last) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Gate with autoEn: the counter clears one edge after autoEn falls
  assign auto_req = autoEn & tick_last;
  assign req      = btn_req | auto_req;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    underrun_d = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!fifo.empty) state_d    = REQ;
          else             underrun_d = 1'b1;
        end
      end
      REQ:     state_d = WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        state_d = IDLE;
        capture = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ren_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ren_q     <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      dataHeld  <= '0;
      heldValid <= 1'b0;
      popCount  <= '0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      busy     <= busy_d;
      underrun <= underrun_d;
      if (capture) begin
        dataHeld  <= fifo.rdData;
        heldValid <= 1'b1;
        popCount  <= popCount + 8'd1;
      end
    end
  end

  assign fifo.ren = ren_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed table, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a pop-timeline model.
module tb_fifo_reader;

  localparam int unsigned DW = 15;
  localparam int unsigned TD = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          button;
  logic          autoEn;
  logic [DW-1:0] dataHeld;
  logic          heldValid;
  logic [7:0]    popCount;
  logic          underrun;
  logic          busy;

  fifo_reader_if #(.DATA_W(DW)) bus ();

  fifo_reader #(.DATA_W(DW), .TICK_DIV(TD)) dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .autoEn   (autoEn),
    .fifo     (bus),
    .dataHeld (dataHeld),
    .heldValid(heldValid),
    .popCount (popCount),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  // FIFO contents (stimulus side)
  logic [DW-1:0] fq[$];

  // Reference model: button sample history, autoEn run length, pop timeline
  int            cyc;
  bit            hist [3];
  int            run_len;
  int            start_cyc;
  int            und_cyc;
  logic [DW-1:0] m_pend;
  logic [DW-1:0] m_held;
  logic          m_valid;
  int            m_count;
  int            ren_seen;
  int            und_seen;

  typedef struct {
    logic          push;
    logic [DW-1:0] val;
    logic [7:0]    exp_cnt;
    logic [DW-1:0] exp_held;
    logic          exp_und;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    button = 1'b1;
    autoEn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    hist[0]   = 1'b1;
    hist[1]   = 1'b1;
    hist[2]   = 1'b1;
    run_len   = 0;
    start_cyc = -100;
    und_cyc   = -100;
    m_held    = '0;
    m_valid   = 1'b0;
    m_count   = 0;
  endtask

  // One clock: predict the effect of the coming edge, take it, compare
  task automatic step();
    bit   req_b, req_a;
    logic ren_before;
    bus.empty = (fq.size() == 0);
    // A press counts once the button is seen high then low two samples later
    req_b = hist[2] && !hist[1];
    req_a = autoEn && ((run_len % int'(TD)) == int'(TD) - 1);
    if ((cyc >= start_cyc + 4) && (req_b || req_a)) begin
      if (!bus.empty) begin
        start_cyc = cyc;
        m_pend    = fq[0];
      end else begin
        und_cyc = cyc;
      end
    end
    if (cyc == start_cyc + 3) begin
      m_held  = m_pend;
      m_valid = 1'b1;
      m_count = (m_count + 1) % 256;
    end
    hist[2]    = hist[1];
    hist[1]    = hist[0];
    hist[0]    = button;
    run_len    = autoEn ? run_len + 1 : 0;
    ren_before = bus.ren;
    @(posedge clock);
    #1;
    if (ren_before && fq.size() > 0) bus.rdData = fq.pop_front();
    bus.empty = (fq.size() == 0);
    chk("ren", 32'(bus.ren), 32'(cyc == start_cyc));
    chk("busy", 32'(busy), 32'((cyc >= start_cyc) && (cyc < start_cyc + 3)));
    chk("underrun", 32'(underrun), 32'(cyc == und_cyc));
    chk("dataHeld", 32'(dataHeld), 32'(m_held));
    chk("heldValid", 32'(heldValid), 32'(m_valid));
    chk("popCount", 32'(popCount), 32'(m_count));
    if (bus.ren) ren_seen++;
    if (underrun) und_seen++;
    cyc++;
    @(negedge clock);
  endtask

  task automatic press(input int low, input int high);
    button = 1'b0;
    repeat (low) step();
    button = 1'b1;
    repeat (high) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    ren_seen    = 0;
    und_seen    = 0;
    m_pend      = '0;
    bus.empty   = 1'b1;
    bus.rdData  = '0;
    tbl[0] = '{1'b1, 15'h1234, 8'd1, 15'h1234, 1'b0};
    tbl[1] = '{1'b1, 15'h0ABC, 8'd2, 15'h0ABC, 1'b0};
    tbl[2] = '{1'b0, 15'h0000, 8'd2, 15'h0ABC, 1'b1};
    tbl[3] = '{1'b1, 15'h7FFF, 8'd3, 15'h7FFF, 1'b0};
    tbl[4] = '{1'b1, 15'h0000, 8'd4, 15'h0000, 1'b0};
    tbl[5] = '{1'b0, 15'h5555, 8'd4, 15'h0000, 1'b1};

    do_reset();
    chk("rst_ren", 32'(bus.ren), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_held", 32'(dataHeld), 32'(0));
    chk("rst_valid", 32'(heldValid), 32'(0));
    chk("rst_count", 32'(popCount), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    repeat (4) step();
    chk("no_req_after_reset", 32'(ren_seen), 32'(0));

    // Directed button presses, one held press per record
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].push) push(tbl[i].val);
      ren_seen = 0;
      und_seen = 0;
      press(5, 7);
      chk("tbl_ren_pulses", 32'(ren_seen), 32'(!tbl[i].exp_und));
      chk("tbl_underruns", 32'(und_seen), 32'(tbl[i].exp_und));
      chk("tbl_popCount", 32'(popCount), 32'(tbl[i].exp_cnt));
      chk("tbl_dataHeld", 32'(dataHeld), 32'(tbl[i].exp_held));
      chk("tbl_heldValid", 32'(heldValid), 32'(1));
    end

    // Auto drain: three entries, ticks at 8/16/24, fourth tick underruns
    do_reset();
    fq.delete();
    push(15'h0111); push(15'h0222); push(15'h0333);
    autoEn = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      chk("auto_ren_slot", 32'(bus.ren), 32'(i == 8 || i == 16 || i == 24));
      chk("auto_underrun_slot", 32'(underrun), 32'(i == 32));
    end
    autoEn = 1'b0;
    chk("auto_count", 32'(popCount), 32'(3));
    chk("auto_held", 32'(dataHeld), 32'(15'h0333));

    // Button coincident with tick merges; second press during WAIT dropped
    do_reset();
    push(15'h0A0A); push(15'h0B0B);
    ren_seen = 0;
    und_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      case (i)
        1:  autoEn = 1'b1;
        6:  button = 1'b0;
        7:  button = 1'b1;
        8:  button = 1'b0;
        9:  button = 1'b1;
        12: autoEn = 1'b0;
        default: ;
      endcase
      step();
      if (i == 8) chk("merge_ren_at_tick", 32'(bus.ren), 32'(1));
    end
    chk("merge_ren_pulses", 32'(ren_seen), 32'(1));
    chk("merge_count", 32'(popCount), 32'(1));
    chk("merge_underruns", 32'(und_seen), 32'(0));
    chk("merge_held", 32'(dataHeld), 32'(15'h0A0A));

    // popCount wrap after 256 back-to-back pops
    do_reset();
    fq.delete();
    for (int i = 0; i < 256; i++) push(DW'($urandom));
    und_seen = 0;
    for (int i = 0; i < 255; i++) press(2, 2);
    repeat (6) step();
    chk("wrap_count_255", 32'(popCount), 32'(255));
    press(2, 2);
    repeat (6) step();
    chk("wrap_count_0", 32'(popCount), 32'(0));
    chk("wrap_valid", 32'(heldValid), 32'(1));
    chk("wrap_busy", 32'(busy), 32'(0));
    chk("wrap_underruns", 32'(und_seen), 32'(0));

    // Reset asserted in WAIT clears outputs without a clock edge
    do_reset();
    fq.delete();
    push(15'h2AAA); push(15'h1555);
    begin
      bit found;
      found  = 1'b0;
      button = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        if (bus.ren) found = 1'b1;
      end
      chk("wait_ren_seen", 32'(found), 32'(1));
    end
    step();
    chk("in_wait_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    chk("async_ren", 32'(bus.ren), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_held", 32'(dataHeld), 32'(0));
    chk("async_valid", 32'(heldValid), 32'(0));
    chk("async_count", 32'(popCount), 32'(0));
    chk("async_underrun", 32'(underrun), 32'(0));
    do_reset();
    ren_seen = 0;
    press(2, 10);
    chk("post_reset_ren", 32'(ren_seen), 32'(1));
    chk("post_reset_count", 32'(popCount), 32'(1));
    chk("post_reset_held", 32'(dataHeld), 32'(15'h1555));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (($urandom_range(3) == 0) && (fq.size() < 8)) push(DW'($urandom));
      if ($urandom_range(4) == 0) button = ~button;
      if ($urandom_range(59) == 0) autoEn = ~autoEn;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 15, width of FIFO read data and held value.
REQ-002 Parameter TICK_DIV, default 50000000, auto-drain period in clock cycles (minimum 4).
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 button  input  1  raw active-low pushbutton, asynchronous to clock; a press is a falling edge.
REQ-006 autoEn  input  1  level; 1 = pop one entry every TICK_DIV cycles.
REQ-007 empty  input  1  FIFO empty flag, synchronous to clock.
REQ-008 rdData  input  DATA_W  FIFO read data, valid on the cycle after ren is sampled high.
REQ-009 ren  output  1  FIFO read strobe, one-cycle pulse per pop.
REQ-010 dataHeld  output  DATA_W  last popped value, held until the next pop completes.
REQ-011 heldValid  output  1  1 once at least one pop has completed since reset.
REQ-012 popCount  output  8  number of completed pops, modulo 256.
REQ-013 underrun  output  1  one-cycle pulse when a request is rejected because empty=1.
REQ-014 busy  output  1  1 while a pop is in flight (state other than IDLE).

Function
REQ-015 button SHALL pass through a two-flop synchronizer plus one edge register; a request SHALL fire on the cycle the synchronized level goes 1->0.
REQ-016 Button-to-request latency SHALL be 3 clocks after the falling edge is sampled; a held button SHALL produce exactly one request.
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 while autoEn=1, wrap to 0, and issue an auto request on the cycle it equals TICK_DIV-1.
REQ-018 Tick counter SHALL clear to 0 on any cycle autoEn=0; the first auto request fires TICK_DIV cycles after autoEn rises.
REQ-019 FSM states: IDLE, REQ, WAIT, CAPTURE.
REQ-020 IDLE: request and empty=0 -> REQ; request and empty=1 -> stay IDLE and pulse underrun next cycle; otherwise stay.
REQ-021 REQ: ren=1 for exactly this cycle -> WAIT.
REQ-022 WAIT: ren=0; FIFO registers read data -> CAPTURE.
REQ-023 CAPTURE: dataHeld<=rdData, heldValid<=1, popCount<=popCount+1 -> IDLE.
REQ-024 A request to dataHeld update SHALL take 4 clocks (IDLE, REQ, WAIT, CAPTURE), and a new pop SHALL start at most every 4 clocks.
REQ-025 Requests arriving while busy=1 SHALL be dropped, with no queuing and no underrun.
REQ-026 Simultaneous button and auto requests in IDLE SHALL merge into a single pop.
REQ-027 popCount SHALL wrap from 255 to 0 without saturating or flagging.
REQ-028 empty SHALL be sampled only in IDLE; a change of empty during REQ/WAIT SHALL NOT abort the pop.
REQ-029 ren SHALL never assert while empty=1 is sampled in IDLE, and never for more than 1 consecutive cycle.
REQ-030 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-031 reset=1 SHALL asynchronously force: state=IDLE, ren=0, dataHeld=0, heldValid=0, popCount=0, underrun=0, busy=0, tick counter=0.
REQ-032 Reset SHALL preset synchronizer and edge flops to 1 (button released), so reset release with the button held up produces no request.
REQ-033 Reset asserted mid-pop (REQ/WAIT/CAPTURE) SHALL abandon the pop; dataHeld and popCount remain 0.
REQ-034 After reset deasserts, the first request SHALL be honoured normally.

Verification
REQ-035 FIFO holds 0x1234, 0x0ABC; two button presses 10 cycles apart -> ren pulses 1 cycle each; dataHeld=0x1234 then 0x0ABC; popCount=2; heldValid=1.
REQ-036 empty=1, button press -> no ren, underrun pulses 1 cycle, dataHeld/popCount unchanged.
REQ-037 TICK_DIV=8, autoEn=1, FIFO with 3 entries -> ren at cycles 8, 16, 24 after autoEn rise; 4th tick -> underrun pulse.
REQ-038 Button edge coincident with auto tick -> exactly one ren; second press during WAIT -> dropped, popCount+1 only.
REQ-039 Preload popCount=255 via 255 pops, one more pop -> popCount=0, no other output disturbed.
REQ-040 reset asserted in WAIT -> all outputs 0 immediately (asynchronous); after release, button press -> normal 4-cycle pop.
